// File: rtl/multi_timer_pkg.sv
// Register map and CTRL/STATUS field layout shared by the multi-channel timer.
package multi_timer_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COMPARE = 2'd1;
  localparam logic [1:0] REG_COUNT   = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_W   = 8;

  localparam int STATUS_TRIG = 0;
  localparam int STATUS_CLR  = 0;

  typedef struct packed {
    logic [CTRL_PRESC_W-1:0] prescale;
    logic                    irq_en;
    logic                    periodic;
    logic                    enable;
  } ctrl_t;

endpackage

// File: rtl/multi_timer_if.sv
// Word-addressed register bus between a bus master and the timer block.
interface multi_timer_if #(
  parameter int AW    = 4,
  parameter int WIDTH = 32
);
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] rdata;

  modport master (output addr, wdata, we, re, input rdata);
  modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/multi_timer_channel.sv
// One timer channel: prescaler, counter/compare, sticky trigger flag and its CTRL bits.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       reg_sel,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] ctrl_word,
  output logic [WIDTH-1:0] compare,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] status_word,
  output logic             triggered,
  output logic             irq_en
);

  ctrl_t                   ctrl;
  logic [CTRL_PRESC_W-1:0] pc;
  logic                    cnt_wr, tick, match, trig_set;
  logic                    unused_wdata;

  // A COUNT write replaces the whole tick, including any trigger it would cause.
  assign cnt_wr   = wr_en && (reg_sel == REG_COUNT);
  assign tick     = ctrl.enable && (pc == ctrl.prescale) && !cnt_wr;
  assign match    = (count == compare);
  assign trig_set = tick && match;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      compare   <= '0;
      count     <= '0;
      pc        <= '0;
      triggered <= 1'b0;
    end else begin
      if (ctrl.enable) begin
        if (tick) begin
          pc <= '0;
          if (match) begin
            count     <= '0;
            triggered <= 1'b1;
            if (!ctrl.periodic) ctrl.enable <= 1'b0;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          pc <= pc + CTRL_PRESC_W'(1);
        end
      end
      // Bus writes come last so they override the timer's own updates.
      if (wr_en) begin
        case (reg_sel)
          REG_CTRL: begin
            ctrl.enable   <= wdata[CTRL_ENABLE];
            ctrl.periodic <= wdata[CTRL_PERIODIC];
            ctrl.irq_en   <= wdata[CTRL_IRQ_EN];
            ctrl.prescale <= wdata[CTRL_PRESC_LSB +: CTRL_PRESC_W];
            if (wdata[CTRL_ENABLE] && !ctrl.enable) pc <= '0;
          end
          REG_COMPARE: compare <= wdata;
          REG_COUNT: begin
            count <= wdata;
            pc    <= '0;
          end
          default: if (wdata[STATUS_CLR] && !trig_set) triggered <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    ctrl_word                                    = '0;
    ctrl_word[CTRL_ENABLE]                       = ctrl.enable;
    ctrl_word[CTRL_PERIODIC]                     = ctrl.periodic;
    ctrl_word[CTRL_IRQ_EN]                       = ctrl.irq_en;
    ctrl_word[CTRL_PRESC_LSB +: CTRL_PRESC_W]    = ctrl.prescale;
    status_word                                  = '0;
    status_word[STATUS_TRIG]                     = triggered;
  end

  assign irq_en       = ctrl.irq_en;
  assign unused_wdata = ^wdata;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: address decode, registered read mux and irq, CHANNELS timer_channel instances.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  multi_timer_if.slave        bus,
  output logic [CHANNELS-1:0] triggered,
  output logic [CHANNELS-1:0] irq
);

  localparam int AW = $clog2(CHANNELS) + 2;

  logic [AW-1:0]                    chan_sel;
  logic [1:0]                       reg_sel;
  logic [CHANNELS-1:0]              wr_en, irq_en;
  logic [CHANNELS-1:0][WIDTH-1:0]   ctrl_w, cmp_w, cnt_w, sts_w;
  logic [WIDTH-1:0]                 rd_mux;

  // Shift rather than slice so a single-channel build (AW==2) still decodes.
  assign chan_sel = bus.addr >> 2;
  assign reg_sel  = bus.addr[1:0];

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < CHANNELS; i++)
      wr_en[i] = bus.we && (int'(chan_sel) == i);
  end

  // Channel indices with no instance fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(chan_sel) == i) begin
        case (reg_sel)
          REG_CTRL:    rd_mux = ctrl_w[i];
          REG_COMPARE: rd_mux = cmp_w[i];
          REG_COUNT:   rd_mux = cnt_w[i];
          default:     rd_mux = sts_w[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata <= '0;
      irq       <= '0;
    end else begin
      irq <= triggered & irq_en;
      if (bus.re) bus.rdata <= rd_mux;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[g]),
      .reg_sel    (reg_sel),
      .wdata      (bus.wdata),
      .ctrl_word  (ctrl_w[g]),
      .compare    (cmp_w[g]),
      .count      (cnt_w[g]),
      .status_word(sts_w[g]),
      .triggered  (triggered[g]),
      .irq_en     (irq_en[g])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: timing predicted from (C+1)(P+1) arithmetic, bus checked against a register model.
module tb_multi_timer;
  import multi_timer_pkg::*;

  localparam int CH = 4;
  localparam int W  = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] triggered, irq;
  logic [2:0]    trig3, irq3;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  multi_timer_if #(.AW(AW), .WIDTH(W)) bus ();
  multi_timer_if #(.AW(4),  .WIDTH(W)) bus3 ();

  multi_timer #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .triggered(triggered), .irq(irq));

  multi_timer #(.CHANNELS(3), .WIDTH(W)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .triggered(trig3), .irq(irq3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wr(input int ch, input logic [1:0] r, input logic [31:0] d);
    bus.addr  = AW'(ch * 4 + int'(r));
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk); #1;
    bus.we    = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [1:0] r, output logic [31:0] d);
    bus.addr = AW'(ch * 4 + int'(r));
    bus.re   = 1'b1;
    @(posedge clk); #1;
    bus.re   = 1'b0;
    d        = bus.rdata;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Leaves the bench just after edge t-1 so the next driven access lands on edge t.
  task automatic go_to(input int t);
    while (cyc < t - 1) begin @(posedge clk); #1; end
  endtask

  task automatic wait_trig(input int ch, input int budget, output int e);
    e = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (triggered[ch]) begin e = cyc; break; end
    end
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    bus.we = 0; bus.re = 0; bus.addr = '0; bus.wdata = '0;
    bus3.we = 0; bus3.re = 0; bus3.addr = '0; bus3.wdata = '0;
    step(3);
    rst = 1'b0;
    total++; if ({triggered, irq, bus.rdata} !== '0) begin bad++; $display("FAIL reset_outputs got trig=%b irq=%b rdata=%h want 0", triggered, irq, bus.rdata); end
    wr(0, REG_COMPARE, 32'd5);
    wr(0, REG_CTRL, 32'h1);
    rd(0, REG_COMPARE, d);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL reset_pre_compare got=%h want=5", d); end
    step(2);
    pulse_rst;
    total++; if (bus.rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
    rd(0, REG_COUNT, d);
    total++; if (d !== '0) begin bad++; $display("FAIL reset_count got=%h want=0", d); end
    rd(0, REG_CTRL, d);
    total++; if (d !== '0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", d); end
    rd(0, REG_COMPARE, d);
    total++; if (d !== '0) begin bad++; $display("FAIL reset_compare got=%h want=0", d); end
    step(20);
    total++; if ({triggered, irq} !== '0) begin bad++; $display("FAIL reset_no_trigger got trig=%b irq=%b want 0", triggered, irq); end
  endtask

  task automatic test_periodic;
    int e, r1, r2, r3;
    pulse_rst;
    wr(0, REG_COMPARE, 32'd3);
    wr(0, REG_CTRL, 32'h7);
    e = cyc;
    wait_trig(0, 50, r1);
    total++; if (r1 - e !== 4) begin bad++; $display("FAIL periodic_first got=%0d want=4", r1 - e); end
    total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL periodic_irq_lag got=%b want=0", irq[0]); end
    step(1);
    total++; if (irq[0] !== 1'b1) begin bad++; $display("FAIL periodic_irq got=%b want=1", irq[0]); end
    wr(0, REG_STATUS, 32'h1);
    total++; if (triggered[0] !== 1'b0) begin bad++; $display("FAIL periodic_clear got=%b want=0", triggered[0]); end
    wait_trig(0, 50, r2);
    total++; if (r2 - r1 !== 4) begin bad++; $display("FAIL periodic_second got=%0d want=4", r2 - r1); end
    wr(0, REG_CTRL, 32'h3);
    wr(0, REG_STATUS, 32'h1);
    wait_trig(0, 50, r3);
    total++; if (r3 - r2 !== 4) begin bad++; $display("FAIL periodic_third got=%0d want=4", r3 - r2); end
    step(2);
    total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL periodic_irq_masked got=%b want=0", irq[0]); end
    wr(0, REG_CTRL, 32'h0);
  endtask

  task automatic test_oneshot;
    int e, r;
    logic [31:0] d;
    pulse_rst;
    wr(1, REG_COMPARE, 32'd9);
    wr(1, REG_CTRL, (32'd4 << 8) | 32'h1);
    e = cyc;
    wait_trig(1, 200, r);
    total++; if (r - e !== 50) begin bad++; $display("FAIL oneshot_rise got=%0d want=50", r - e); end
    rd(1, REG_CTRL, d);
    total++; if (d !== 32'h400) begin bad++; $display("FAIL oneshot_ctrl got=%h want=400", d); end
    rd(1, REG_COUNT, d);
    total++; if (d !== '0) begin bad++; $display("FAIL oneshot_count got=%h want=0", d); end
    step(200);
    rd(1, REG_COUNT, d);
    total++; if (d !== '0) begin bad++; $display("FAIL oneshot_hold got=%h want=0", d); end
    total++; if (triggered[1] !== 1'b1) begin bad++; $display("FAIL oneshot_sticky got=%b want=1", triggered[1]); end
  endtask

  task automatic test_scaled;
    int prev, r;
    logic [31:0] d;
    pulse_rst;
    wr(3, REG_COMPARE, 32'd99);
    wr(3, REG_CTRL, (32'd49 << 8) | 32'h3);
    prev = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_trig(3, 6000, r);
      total++; if (r - prev !== 5000) begin bad++; $display("FAIL scaled_period%0d got=%0d want=5000", k, r - prev); end
      wr(3, REG_STATUS, 32'h1);
      prev = r;
    end
    for (int c = 0; c < 3; c++) begin
      rd(c, REG_COUNT, d);
      total++; if (d !== '0) begin bad++; $display("FAIL scaled_idle_ch%0d got=%h want=0", c, d); end
    end
  endtask

  task automatic test_periodic_random;
    int p, c, ch, t, prev, r;
    for (int it = 0; it < 4; it++) begin
      pulse_rst;
      p  = int'($urandom_range(1, 5));
      c  = int'($urandom_range(1, 6));
      ch = int'($urandom_range(0, 3));
      t  = (c + 1) * (p + 1);
      wr(ch, REG_COMPARE, 32'(c));
      wr(ch, REG_CTRL, (32'(p) << 8) | 32'h3);
      prev = cyc;
      for (int k = 0; k < 3; k++) begin
        wait_trig(ch, t + 10, r);
        total++; if (r - prev !== t) begin bad++; $display("FAIL rand_period ch=%0d P=%0d C=%0d got=%0d want=%0d", ch, p, c, r - prev, t); end
        wr(ch, REG_STATUS, 32'h1);
        prev = r;
      end
    end
  endtask

  task automatic test_boundary;
    int e;
    logic [31:0] d;
    pulse_rst;
    wr(2, REG_COMPARE, 32'd0);
    wr(2, REG_COUNT, 32'hFFFF_FFFF);
    wr(2, REG_CTRL, (32'd3 << 8) | 32'h3);
    e = cyc;
    rd(2, REG_COUNT, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL bnd_max got=%h want=ffffffff", d); end
    go_to(e + 5);
    rd(2, REG_COUNT, d);
    total++; if (d !== '0) begin bad++; $display("FAIL bnd_wrap got=%h want=0", d); end
    go_to(e + 8);
    total++; if (triggered[2] !== 1'b0) begin bad++; $display("FAIL bnd_no_early got=%b want=0", triggered[2]); end
    wr(2, REG_STATUS, 32'h1);
    total++; if (triggered[2] !== 1'b1) begin bad++; $display("FAIL bnd_set_wins got=%b want=1", triggered[2]); end
    wr(2, REG_STATUS, 32'h1);
    total++; if (triggered[2] !== 1'b0) begin bad++; $display("FAIL bnd_clear got=%b want=0", triggered[2]); end
    while (cyc < e + 12) step(1);
    total++; if (triggered[2] !== 1'b1) begin bad++; $display("FAIL bnd_retrigger got=%b want=1", triggered[2]); end
  endtask

  task automatic test_bus;
    logic [31:0] m_ctrl [CH];
    logic [31:0] m_cmp  [CH];
    logic [31:0] m_cnt  [CH];
    logic [31:0] d, wv, old;
    pulse_rst;
    for (int c = 0; c < CH; c++) begin
      wv = $urandom & ~32'h1;
      m_ctrl[c] = wv & 32'h0000_FF06;
      wr(c, REG_CTRL, wv);
      m_cmp[c] = $urandom;
      wr(c, REG_COMPARE, m_cmp[c]);
      m_cnt[c] = $urandom;
      wr(c, REG_COUNT, m_cnt[c]);
    end
    for (int c = 0; c < CH; c++) begin
      rd(c, REG_CTRL, d);
      total++; if (d !== m_ctrl[c]) begin bad++; $display("FAIL bus_ctrl ch%0d got=%h want=%h", c, d, m_ctrl[c]); end
      rd(c, REG_COMPARE, d);
      total++; if (d !== m_cmp[c]) begin bad++; $display("FAIL bus_compare ch%0d got=%h want=%h", c, d, m_cmp[c]); end
      rd(c, REG_COUNT, d);
      total++; if (d !== m_cnt[c]) begin bad++; $display("FAIL bus_count ch%0d got=%h want=%h", c, d, m_cnt[c]); end
      rd(c, REG_STATUS, d);
      total++; if (d !== '0) begin bad++; $display("FAIL bus_status ch%0d got=%h want=0", c, d); end
    end
    rd(2, REG_COUNT, d);
    step(3);
    total++; if (bus.rdata !== m_cnt[2]) begin bad++; $display("FAIL bus_hold got=%h want=%h", bus.rdata, m_cnt[2]); end
    old = m_cmp[1];
    wv  = ~old;
    bus.addr = AW'(1 * 4 + int'(REG_COMPARE));
    bus.wdata = wv; bus.we = 1'b1; bus.re = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0; bus.re = 1'b0;
    total++; if (bus.rdata !== old) begin bad++; $display("FAIL bus_rw_same got=%h want=%h", bus.rdata, old); end
    rd(1, REG_COMPARE, d);
    total++; if (d !== wv) begin bad++; $display("FAIL bus_rw_after got=%h want=%h", d, wv); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] v;
    v = $urandom | 32'h1;
    bus3.addr = 4'h9; bus3.wdata = v; bus3.we = 1'b1;
    @(posedge clk); #1; bus3.we = 1'b0;
    bus3.re = 1'b1;
    @(posedge clk); #1; bus3.re = 1'b0;
    total++; if (bus3.rdata !== v) begin bad++; $display("FAIL oor_valid got=%h want=%h", bus3.rdata, v); end
    bus3.addr = 4'hD; bus3.wdata = ~v; bus3.we = 1'b1;
    @(posedge clk); #1; bus3.we = 1'b0;
    bus3.re = 1'b1;
    @(posedge clk); #1; bus3.re = 1'b0;
    total++; if (bus3.rdata !== '0) begin bad++; $display("FAIL oor_read got=%h want=0", bus3.rdata); end
    bus3.addr = 4'hE;
    bus3.re = 1'b1;
    @(posedge clk); #1; bus3.re = 1'b0;
    total++; if ({bus3.rdata, trig3, irq3} !== '0) begin bad++; $display("FAIL oor_count got=%h trig=%b want 0", bus3.rdata, trig3); end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_oneshot;
    test_scaled;
    test_periodic_random;
    test_boundary;
    test_bus;
    test_out_of_range;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
